// File: rtl/ysyx_22041211_stage_buf_pkg.sv
// Types, defaults and count helper shared by the stage buffer and its pointer counters.
package ysyx_22041211_stage_buf_pkg;

`include "ysyx_22041211_define.v"

  localparam int unsigned DefDataLen = `YSYX_22041211_DATA_LEN;
  localparam int unsigned DefDepth   = `YSYX_22041211_DEPTH;

  // Encoded as {push, pop} so the handshake bits cast straight onto it.
  typedef enum logic [1:0] {
    OpIdle = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } op_e;

  function automatic logic [4:0] count_step(input logic [4:0] cnt, input op_e op);
    logic [4:0] nxt;
    nxt = cnt;
    unique case (op)
      OpPush:         nxt = cnt + 5'd1;
      OpPop:          nxt = cnt - 5'd1;
      OpIdle, OpBoth: nxt = cnt;
      default:        nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ysyx_22041211_define.v
// Shared handshake constants for the ysyx_22041211 pipeline stages.
`ifndef YSYX_22041211_DEFINE_V
`define YSYX_22041211_DEFINE_V

`define YSYX_22041211_DATA_LEN 32
`define YSYX_22041211_DEPTH    2

`endif

// File: rtl/ysyx_22041211_ring_ptr.sv
// Wrapping ring pointer: increments when inc is high, synchronous clear wins over inc.
module ysyx_22041211_ring_ptr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ysyx_22041211_stage_buf.sv
// Ring-buffered valid/ready pipeline stage with synchronous flush.
// Optional combinational bypass when empty: define YSYX_22041211_STAGE_BUF_BYPASS_EN.
module ysyx_22041211_stage_buf
  import ysyx_22041211_stage_buf_pkg::*;
#(
  parameter int unsigned DATA_LEN = DefDataLen,
  parameter int unsigned DEPTH    = DefDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_valid,
  input  logic [DATA_LEN-1:0]    in_data,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  output logic [DATA_LEN-1:0]    out_data_o,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]     wr_ptr, rd_ptr;
  logic [CntW-1:0]     count_q, count_d;
  logic [DATA_LEN-1:0] mem_q [DEPTH];
  logic [DATA_LEN-1:0] head;
  logic                push, pop, empty;
  op_e                 op;

  assign empty      = (count_q == '0);
  assign in_ready_o = (count_q < CntW'(DEPTH));
  assign count_o    = count_q;
  assign head       = empty ? '0 : mem_q[rd_ptr];
  assign pop        = ~empty & out_ready;

`ifdef YSYX_22041211_STAGE_BUF_BYPASS_EN
  logic byp_on, byp_take;

  // Held off during reset so the outputs read idle regardless of in_valid.
  assign byp_on      = empty & rst;
  assign byp_take    = byp_on & in_valid & out_ready;
  assign out_valid_o = byp_on ? in_valid : ~empty;
  assign out_data_o  = byp_on ? in_data : head;
  assign push        = in_valid & in_ready_o & ~byp_take;
`else
  assign out_valid_o = ~empty;
  assign out_data_o  = head;
  assign push        = in_valid & in_ready_o;
`endif

  always_comb begin
    op = op_e'({push, pop});
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d = CntW'(count_step(5'(count_q), op));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A push in the flush cycle is dropped, so storage is left untouched too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush_i) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  ysyx_22041211_ring_ptr #(
    .WIDTH(PtrW)
  ) u_wr_ptr (
    .clk(clk),
    .rst(rst),
    .clr(flush_i),
    .inc(push & ~flush_i),
    .ptr(wr_ptr)
  );

  ysyx_22041211_ring_ptr #(
    .WIDTH(PtrW)
  ) u_rd_ptr (
    .clk(clk),
    .rst(rst),
    .clr(flush_i),
    .inc(pop & ~flush_i),
    .ptr(rd_ptr)
  );

endmodule

// File: tb/tb_ysyx_22041211_stage_buf.sv
// Directed bench for the stage buffer: a DEPTH=4 and a DEPTH=2 instance share clock and reset.
module tb_ysyx_22041211_stage_buf;

`ifdef YSYX_22041211_STAGE_BUF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 27;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        fl4, iv4, or4, ir4, ov4;
  logic [31:0] id4, od4;
  logic [2:0]  cnt4;
  logic        fl2, iv2, or2, ir2, ov2;
  logic [31:0] id2, od2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  vec_t        tbl [NV];
  vec_t        v;
  logic        exp_ov;
  logic [31:0] exp_od;

  ysyx_22041211_stage_buf #(.DATA_LEN(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush_i(fl4), .in_valid(iv4), .in_data(id4), .in_ready_o(ir4),
    .out_valid_o(ov4), .out_data_o(od4), .out_ready(or4), .count_o(cnt4)
  );

  ysyx_22041211_stage_buf #(.DATA_LEN(32), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush_i(fl2), .in_valid(iv2), .in_data(id2), .in_ready_o(ir2),
    .out_valid_o(ov2), .out_data_o(od2), .out_ready(or2), .count_o(cnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic eir, input logic eov,
                              input logic [31:0] eod, input logic [2:0] ecnt);
    vec_t r;
    r.fl = fl; r.iv = iv; r.d = d; r.ordy = ordy;
    r.e_ir = eir; r.e_ov = eov; r.e_od = eod; r.e_cnt = ecnt;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // fill / refuse / drain
    tbl[0]  = mk(0, 1, 32'd1,     0, 1, 0, 32'd0,     3'd0);
    tbl[1]  = mk(0, 1, 32'd2,     0, 1, 1, 32'd1,     3'd1);
    tbl[2]  = mk(0, 1, 32'd3,     0, 1, 1, 32'd1,     3'd2);
    tbl[3]  = mk(0, 1, 32'd4,     0, 1, 1, 32'd1,     3'd3);
    tbl[4]  = mk(0, 1, 32'd5,     0, 0, 1, 32'd1,     3'd4);
    tbl[5]  = mk(0, 0, 32'd0,     1, 0, 1, 32'd1,     3'd4);
    tbl[6]  = mk(0, 0, 32'd0,     1, 1, 1, 32'd2,     3'd3);
    tbl[7]  = mk(0, 0, 32'd0,     1, 1, 1, 32'd3,     3'd2);
    tbl[8]  = mk(0, 0, 32'd0,     1, 1, 1, 32'd4,     3'd1);
    tbl[9]  = mk(0, 0, 32'd0,     1, 1, 0, 32'd0,     3'd0);
    // flush with a concurrent push of 0xAA
    tbl[10] = mk(0, 1, 32'h10,    0, 1, 0, 32'd0,     3'd0);
    tbl[11] = mk(0, 1, 32'h11,    0, 1, 1, 32'h10,    3'd1);
    tbl[12] = mk(0, 1, 32'h12,    0, 1, 1, 32'h10,    3'd2);
    tbl[13] = mk(1, 1, 32'hAA,    0, 1, 1, 32'h10,    3'd3);
    tbl[14] = mk(0, 0, 32'd0,     1, 1, 0, 32'd0,     3'd0);
    tbl[15] = mk(0, 0, 32'd0,     1, 1, 0, 32'd0,     3'd0);
    // backpressure holding 0x1234
    tbl[16] = mk(0, 1, 32'h1234,  0, 1, 0, 32'd0,     3'd0);
    tbl[17] = mk(0, 1, 32'h5000,  0, 1, 1, 32'h1234,  3'd1);
    tbl[18] = mk(0, 1, 32'h5001,  0, 1, 1, 32'h1234,  3'd2);
    tbl[19] = mk(0, 1, 32'h5002,  0, 1, 1, 32'h1234,  3'd3);
    tbl[20] = mk(0, 1, 32'h5003,  0, 0, 1, 32'h1234,  3'd4);
    tbl[21] = mk(0, 0, 32'd0,     0, 0, 1, 32'h1234,  3'd4);
    tbl[22] = mk(0, 0, 32'd0,     1, 0, 1, 32'h1234,  3'd4);
    tbl[23] = mk(0, 0, 32'd0,     1, 1, 1, 32'h5000,  3'd3);
    tbl[24] = mk(0, 0, 32'd0,     1, 1, 1, 32'h5001,  3'd2);
    tbl[25] = mk(0, 0, 32'd0,     1, 1, 1, 32'h5002,  3'd1);
    tbl[26] = mk(0, 0, 32'd0,     1, 1, 0, 32'd0,     3'd0);

    // reset held for 3 cycles with a valid payload offered
    rst = 1'b0;
    fl4 = 0; iv4 = 1; id4 = 32'hDEAD_BEEF; or4 = 0;
    fl2 = 0; iv2 = 1; id2 = 32'hDEAD_BEEF; or2 = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d d4 in_ready", c), 32'(ir4), 32'd1);
      check($sformatf("rst%0d d4 out_valid", c), 32'(ov4), 32'd0);
      check($sformatf("rst%0d d4 out_data", c), od4, 32'd0);
      check($sformatf("rst%0d d4 count", c), 32'(cnt4), 32'd0);
      check($sformatf("rst%0d d2 in_ready", c), 32'(ir2), 32'd1);
      check($sformatf("rst%0d d2 out_valid", c), 32'(ov2), 32'd0);
      check($sformatf("rst%0d d2 out_data", c), od2, 32'd0);
      check($sformatf("rst%0d d2 count", c), 32'(cnt2), 32'd0);
    end
    cyc();
    rst = 1'b1;
    iv4 = 0; id4 = 0; iv2 = 0; id2 = 0;
    cyc();

    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      fl4 = v.fl; iv4 = v.iv; id4 = v.d; or4 = v.ordy;
      exp_ov = v.e_ov;
      exp_od = v.e_od;
      if (Byp && v.e_cnt == 3'd0) begin
        exp_ov = v.iv;
        exp_od = v.d;
      end
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), 32'(ir4), 32'(v.e_ir));
      check($sformatf("vec%0d out_valid", i), 32'(ov4), 32'(exp_ov));
      check($sformatf("vec%0d out_data", i), od4, exp_od);
      check($sformatf("vec%0d count", i), 32'(cnt4), 32'(v.e_cnt));
      cyc();
    end
    fl4 = 0; iv4 = 0; id4 = 0; or4 = 0;

    // asynchronous reset mid-transfer, checked before any clock edge
    iv4 = 1; id4 = 32'h77;
    cyc();
    iv4 = 0; id4 = 0;
    @(negedge clk);
    check("midrst pre count", 32'(cnt4), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst count", 32'(cnt4), 32'd0);
    check("midrst out_valid", 32'(ov4), 32'd0);
    check("midrst out_data", od4, 32'd0);
    check("midrst in_ready", 32'(ir4), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();

    // streaming 0..9 through the DEPTH=2 instance
    for (int k = 0; k < 10; k++) begin
      iv2 = 1; id2 = 32'(k); or2 = 1;
      @(negedge clk);
      check($sformatf("stream%0d out_valid", k), 32'(ov2), (Byp || k != 0) ? 32'd1 : 32'd0);
      check($sformatf("stream%0d out_data", k), od2,
            Byp ? 32'(k) : (k == 0 ? 32'd0 : 32'(k - 1)));
      check($sformatf("stream%0d count", k), 32'(cnt2), (Byp || k == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    iv2 = 0; id2 = 0; or2 = 1;
    @(negedge clk);
    check("stream tail out_valid", 32'(ov2), Byp ? 32'd0 : 32'd1);
    check("stream tail out_data", od2, Byp ? 32'd0 : 32'd9);
    cyc();
    @(negedge clk);
    check("stream end out_valid", 32'(ov2), 32'd0);
    check("stream end count", 32'(cnt2), 32'd0);
    cyc();

    // bypass vs. registered latency on an empty buffer
    iv2 = 1; id2 = 32'd5; or2 = 1;
    @(negedge clk);
    check("byp same out_valid", 32'(ov2), Byp ? 32'd1 : 32'd0);
    check("byp same out_data", od2, Byp ? 32'd5 : 32'd0);
    check("byp same count", 32'(cnt2), 32'd0);
    cyc();
    iv2 = 0; id2 = 0;
    @(negedge clk);
    check("byp next out_valid", 32'(ov2), Byp ? 32'd0 : 32'd1);
    check("byp next out_data", od2, Byp ? 32'd0 : 32'd5);
    check("byp next count", 32'(cnt2), Byp ? 32'd0 : 32'd1);
    cyc();
    @(negedge clk);
    check("byp end count", 32'(cnt2), 32'd0);
    cyc();

    // flush while full and popping: pop adds nothing
    iv2 = 1; id2 = 32'h21; or2 = 0;
    cyc();
    id2 = 32'h22;
    cyc();
    iv2 = 0; id2 = 0; fl2 = 1; or2 = 1;
    @(negedge clk);
    check("flpop in_ready", 32'(ir2), 32'd0);
    check("flpop out_data", od2, 32'h21);
    check("flpop count", 32'(cnt2), 32'd2);
    cyc();
    fl2 = 0; or2 = 0;
    @(negedge clk);
    check("flpop after count", 32'(cnt2), 32'd0);
    check("flpop after out_valid", 32'(ov2), 32'd0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
